// File: rtl/piano_pkg.sv
// Shared constants and helpers for the piano key front end: live-mode codes,
// default timing parameters and a population count used for press_count.
package piano_pkg;

  localparam int NUM_KEYS_DEF         = 17;
  localparam int DEBOUNCE_CYCLES_DEF  = 50000;
  localparam int DEMO_HOLD_CYCLES_DEF = 2500000;

  localparam logic [7:0] LIVE_MODE_A_DEF = 8'd16;
  localparam logic [7:0] LIVE_MODE_B_DEF = 8'd18;

  // Widest key vector the popcount helper accepts.
  localparam int MAX_KEYS = 64;

  function automatic int unsigned popcount(input logic [MAX_KEYS-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MAX_KEYS; i++) cnt += 32'(v[i]);
    return cnt;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key line: two-flop synchronizer followed by a counter debouncer that
// accepts a new level only after DEBOUNCE_CYCLES consecutive differing samples.
module key_debounce
  import piano_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk50,
  input  logic reset_n,
  input  logic key_raw,
  output logic key_stable
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      stable  <= 1'b0;
      cnt     <= '0;
    end else begin
      // synchronizer stage boundary
      sync_p0 <= key_raw;
      sync_p1 <= sync_p0;
      // debounce stage boundary
      if (sync_p1 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign key_stable = stable;

endmodule

// File: rtl/press_merge.sv
// Merges debounced live key switches (gated by mode) with demo-driven keys
// that are stretched to a minimum hold time, and derives edge pulses and a count.
module press_merge
  import piano_pkg::*;
#(
  parameter int         NUM_KEYS         = NUM_KEYS_DEF,
  parameter int         DEBOUNCE_CYCLES  = DEBOUNCE_CYCLES_DEF,
  parameter int         DEMO_HOLD_CYCLES = DEMO_HOLD_CYCLES_DEF,
  parameter logic [7:0] LIVE_MODE_A      = LIVE_MODE_A_DEF,
  parameter logic [7:0] LIVE_MODE_B      = LIVE_MODE_B_DEF
) (
  input  logic                          clk50,
  input  logic                          reset_n,
  input  logic [7:0]                    audio_demo,
  input  logic [7:0]                    mode_select,
  input  logic [NUM_KEYS-1:0]           press_real,
  output logic [NUM_KEYS-1:0]           press,
  output logic [NUM_KEYS-1:0]           press_rise,
  output logic [NUM_KEYS-1:0]           press_fall,
  output logic [$clog2(NUM_KEYS+1)-1:0] press_count
);

  localparam int CNT_W  = $clog2(NUM_KEYS + 1);
  localparam int HOLD_W = $clog2(DEMO_HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(DEMO_HOLD_CYCLES);
  localparam logic [7:0]        KEY_LIMIT = 8'(NUM_KEYS);

  logic [NUM_KEYS-1:0] live_stable;
  logic                live_en;
  logic [7:0]          demo_idx;
  logic [7:0]          cur_key;
  logic [7:0]          held_key;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [HOLD_W-1:0]   hold_cnt_inc;
  logic                hold_done;
  logic [NUM_KEYS-1:0] demo_bits;
  logic [NUM_KEYS-1:0] press_nxt;
  logic [NUM_KEYS-1:0] press_prev_p1;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk50     (clk50),
      .reset_n   (reset_n),
      .key_raw   (press_real[i]),
      .key_stable(live_stable[i])
    );
  end

  // Index 0 and anything past the last key mean "no demo key".
  assign demo_idx     = (audio_demo != 8'd0 && audio_demo < KEY_LIMIT) ? audio_demo : 8'd0;
  assign hold_done    = (hold_cnt == HOLD_MAX);
  assign hold_cnt_inc = hold_done ? hold_cnt : hold_cnt + 1'b1;

  always_comb begin
    demo_bits = '0;
    for (int i = 1; i < NUM_KEYS; i++) begin
      if (cur_key == 8'(i) || held_key == 8'(i)) demo_bits[i] = 1'b1;
    end
  end

  // The counter times the current key from its assertion; a key that was
  // just left stays lit until that same counter saturates.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      cur_key  <= '0;
      held_key <= '0;
      hold_cnt <= '0;
    end else if (demo_idx != cur_key) begin
      cur_key <= demo_idx;
      if (demo_idx != 8'd0) begin
        held_key <= cur_key;
        hold_cnt <= HOLD_W'(1);
      end else begin
        held_key <= hold_done ? 8'd0 : cur_key;
        hold_cnt <= hold_cnt_inc;
      end
    end else begin
      if (hold_done) held_key <= '0;
      hold_cnt <= hold_cnt_inc;
    end
  end

  assign press_nxt = (live_stable & {NUM_KEYS{live_en}}) | demo_bits;

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      live_en       <= 1'b0;
      press         <= '0;
      press_count   <= '0;
      press_prev_p1 <= '0;
      press_rise    <= '0;
      press_fall    <= '0;
    end else begin
      // merge stage boundary
      live_en     <= (mode_select == LIVE_MODE_A) || (mode_select == LIVE_MODE_B);
      press       <= press_nxt;
      press_count <= CNT_W'(popcount(MAX_KEYS'(press_nxt)));
      // edge-detect stage boundary
      press_prev_p1 <= press;
      press_rise    <= press & ~press_prev_p1;
      press_fall    <= ~press & press_prev_p1;
    end
  end

endmodule

// File: tb/tb_press_merge.sv
// Scoreboard bench for press_merge: a cycle-level reference model predicts every
// output word, and an independent monitor compares it against the design.
module tb_press_merge;

  localparam int NK = 17;
  localparam int DB = 4;
  localparam int DH = 8;

  logic          clk50 = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    audio_demo = 8'd0;
  logic [7:0]    mode_select = 8'd0;
  logic [NK-1:0] press_real = '0;
  logic [NK-1:0] press;
  logic [NK-1:0] press_rise;
  logic [NK-1:0] press_fall;
  logic [4:0]    press_count;

  press_merge #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (DB),
    .DEMO_HOLD_CYCLES(DH),
    .LIVE_MODE_A     (8'd16),
    .LIVE_MODE_B     (8'd18)
  ) dut (
    .clk50      (clk50),
    .reset_n    (reset_n),
    .audio_demo (audio_demo),
    .mode_select(mode_select),
    .press_real (press_real),
    .press      (press),
    .press_rise (press_rise),
    .press_fall (press_fall),
    .press_count(press_count)
  );

  always #5 clk50 = ~clk50;

  typedef struct packed {
    logic [NK-1:0] p;
    logic [NK-1:0] r;
    logic [NK-1:0] f;
    logic [4:0]    c;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference state: raw sample history, accepted live levels, demo bookkeeping.
  logic [NK-1:0] samp[$];
  logic [NK-1:0] m_stable;
  logic [NK-1:0] m_press;
  logic [NK-1:0] m_pprev;
  logic          m_len;
  int            m_cur;
  int            m_held;
  int            m_start;
  int            cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    samp.delete();
    for (int i = 0; i < DB + 2; i++) samp.push_back('0);
    m_stable = '0;
    m_press  = '0;
    m_pprev  = '0;
    m_len    = 1'b0;
    m_cur    = 0;
    m_held   = 0;
    m_start  = 0;
    cyc      = 0;
  endtask

  task automatic model_step();
    exp_t          e;
    logic [NK-1:0] demo;
    logic [NK-1:0] nxt;
    int            idx;
    int            last;
    bit            all_diff;
    cyc++;
    demo = '0;
    if (m_cur != 0) demo[m_cur] = 1'b1;
    if (m_held != 0) demo[m_held] = 1'b1;
    nxt = (m_stable & {NK{m_len}}) | demo;
    e.p = nxt;
    e.r = m_press & ~m_pprev;
    e.f = ~m_press & m_pprev;
    e.c = 5'($countones(nxt));
    exp_q.push_back(e);
    m_pprev = m_press;
    m_press = nxt;
    // A level is accepted once DB consecutive raw samples, seen two flops late, disagree with it.
    samp.push_back(press_real);
    if (samp.size() > DB + 2) void'(samp.pop_front());
    last = samp.size() - 1;
    for (int b = 0; b < NK; b++) begin
      all_diff = 1'b1;
      for (int j = 2; j <= DB + 1; j++) if (samp[last-j][b] == m_stable[b]) all_diff = 1'b0;
      if (all_diff) m_stable[b] = ~m_stable[b];
    end
    m_len = (mode_select == 8'd16) || (mode_select == 8'd18);
    idx = (audio_demo >= 8'd1 && audio_demo < 8'(NK)) ? int'(audio_demo) : 0;
    if (idx != m_cur) begin
      if (idx != 0) begin
        m_held  = m_cur;
        m_cur   = idx;
        m_start = cyc;
      end else begin
        m_held = (cyc - m_start < DH) ? m_cur : 0;
        m_cur  = 0;
      end
    end else if (m_held != 0 && cyc - m_start >= DH) begin
      m_held = 0;
    end
  endtask

  initial begin : model
    model_clear();
    forever begin
      @(posedge clk50 or negedge reset_n);
      if (!reset_n) begin
        model_clear();
        exp_q.delete();
      end else begin
        model_step();
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk50);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("press", 32'(press), 32'(e.p));
        chk("press_rise", 32'(press_rise), 32'(e.r));
        chk("press_fall", 32'(press_fall), 32'(e.f));
        chk("press_count", 32'(press_count), 32'(e.c));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk50);
  endtask

  task automatic do_reset(input int n);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_press", 32'(press), 32'd0);
    chk("rst_rise", 32'(press_rise), 32'd0);
    chk("rst_fall", 32'(press_fall), 32'd0);
    chk("rst_count", 32'(press_count), 32'd0);
    repeat (n) @(negedge clk50);
    #1 reset_n = 1'b1;
  endtask

  logic [7:0]    modes[4] = '{8'd0, 8'd3, 8'd16, 8'd18};
  logic [NK-1:0] flip;
  int            r;

  initial begin : stim
    cycles(3);
    chk("init_press", 32'(press), 32'd0);
    chk("init_count", 32'(press_count), 32'd0);
    #1 reset_n = 1'b1;

    // Held live press, then release, then a glitch shorter than the debounce.
    mode_select = 8'd16;
    cycles(2);
    press_real[5] = 1'b1;
    cycles(12);
    press_real[5] = 1'b0;
    cycles(10);
    press_real[5] = 1'b1;
    cycles(3);
    press_real[5] = 1'b0;
    cycles(10);

    // Non-live mode masks everything; a live mode exposes all keys.
    mode_select = 8'd3;
    press_real  = '1;
    cycles(10);
    chk("masked", 32'(press), 32'd0);
    mode_select = 8'd18;
    cycles(10);
    chk("count_all", 32'(press_count), 32'd17);
    press_real  = '0;
    mode_select = 8'd16;
    cycles(10);

    // Short demo tap, then a quick run of demo keys and an out-of-range index.
    audio_demo = 8'd7;
    cycles(2);
    audio_demo = 8'd0;
    cycles(14);
    audio_demo = 8'd3;
    cycles(1);
    audio_demo = 8'd4;
    cycles(1);
    audio_demo = 8'd5;
    cycles(4);
    audio_demo = 8'd20;
    cycles(14);

    // Live key 1 plus demo key 7 in hold, then reset in the middle of it.
    press_real[1] = 1'b1;
    cycles(10);
    audio_demo = 8'd7;
    cycles(2);
    audio_demo = 8'd0;
    cycles(2);
    chk("mid_hold", 32'(press), 32'h82);
    do_reset(2);
    @(posedge clk50);
    #1;
    chk("post_rst_press", 32'(press), 32'd0);
    chk("post_rst_rise", 32'(press_rise), 32'd0);
    chk("post_rst_fall", 32'(press_fall), 32'd0);
    cycles(12);

    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        flip = '0;
        flip[$urandom_range(0, NK-1)] = 1'b1;
        press_real = press_real ^ flip;
      end
      if (r >= 90) begin
        case ($urandom_range(0, 5))
          0:       audio_demo = 8'd0;
          1, 2, 3: audio_demo = 8'($urandom_range(1, NK-1));
          4:       audio_demo = 8'($urandom_range(NK, 255));
          default: audio_demo = audio_demo;
        endcase
      end
      if (r == 50 || r == 51) mode_select = modes[$urandom_range(0, 3)];
      if (i == 700) do_reset(3);
      cycles(1);
    end
    cycles(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/press_merge.md
PRESS_MERGE -- requirements
Module: press_merge

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 17, number of key lines (bit 0 reserved, never demo-driven).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000, consecutive stable cycles required to accept a live key change (minimum 1).
REQ-003 SHALL have parameter DEMO_HOLD_CYCLES, default 2500000, minimum asserted time of a demo key (minimum 1).
REQ-004 SHALL have parameters LIVE_MODE_A, default 8'd16, and LIVE_MODE_B, default 8'd18, the mode_select values enabling live keys.
REQ-005 clk50  input  1  single clock; all logic on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 audio_demo  input  8  demo key index, synchronous to clk50; 0 or >= NUM_KEYS = no demo key.
REQ-008 mode_select  input  8  current mode, synchronous to clk50.
REQ-009 press_real  input  NUM_KEYS  raw asynchronous key switches, 1 = pressed.
REQ-010 press  output  NUM_KEYS  merged key state, registered.
REQ-011 press_rise  output  NUM_KEYS  one-cycle pulse per bit on press 0->1.
REQ-012 press_fall  output  NUM_KEYS  one-cycle pulse per bit on press 1->0.
REQ-013 press_count  output  $clog2(NUM_KEYS+1)  number of set bits in press, same cycle as press.

Function
REQ-014 Each press_real bit SHALL pass a 2-flop synchronizer, then a per-key debouncer holding a stable state and a counter.
REQ-015 Debouncer: sync != stable increments counter; sync == stable clears it; stable toggles and counter clears on the edge where counter == DEBOUNCE_CYCLES-1 while still differing.
REQ-016 A press_real change held constant SHALL appear on press at rising edge DEBOUNCE_CYCLES+3, counting the first edge sampling the new value as edge 1; shorter glitches SHALL not appear.
REQ-017 live_en SHALL be registered as (mode_select == LIVE_MODE_A) or (mode_select == LIVE_MODE_B); debounced live state masked by live_en; debouncers keep running while masked.
REQ-018 Demo decoder: audio_demo = k, 1 <= k < NUM_KEYS, SHALL assert demo bit k on the next edge, press bit k one edge later.
REQ-019 Demo hold: one hold counter for the current demo key, started at assertion; when audio_demo moves off key k, bit k SHALL stay set until the counter reaches DEMO_HOLD_CYCLES, then clear.
REQ-020 If the demo index changes again while a previous key is in hold, the held key SHALL clear immediately and the key just left SHALL become the held key.
REQ-021 Re-selecting a key in hold SHALL cancel the hold and restart its counter as the current key.
REQ-022 press SHALL equal (masked live state) OR (demo bits), registered; bit 0 from live only.
REQ-023 press_rise/press_fall SHALL be registered edge detects of press, asserted in the cycle after press changes.
REQ-024 press_count SHALL be computed from the press next-state and registered with press; width rule NUM_KEYS = 17 -> 5 bits.
REQ-025 Simultaneous live and demo on same key SHALL yield one press bit, no extra rise/fall pulse.

Reset
REQ-026 reset_n low SHALL asynchronously clear synchronizers, debouncer states/counters, live_en, demo bits, hold counter, press, press_rise, press_fall, press_count to 0.
REQ-027 Release of reset mid-press SHALL restart full debounce; no output pulses in the first cycle after release.

Structure
REQ-028 Live-mode constants, default timing parameters and a popcount function SHALL live in shared package piano_pkg.
REQ-029 The per-key synchronizer+debouncer SHALL be sub-module key_debounce, instantiated NUM_KEYS times via generate.

Verification (NUM_KEYS=17, DEBOUNCE_CYCLES=4, DEMO_HOLD_CYCLES=8)
REQ-030 mode_select=16, press_real[5] 0->1 held -> press[5]=1 at edge 7, press_rise[5] pulse at edge 8, press_count=1.
REQ-031 mode_select=16, press_real[5] high for 3 cycles only -> press stays 0, no pulses.
REQ-032 mode_select=3, press_real=17'h1FFFF -> press=0; switch mode to 18 -> press=17'h1FFFF two edges later, press_count=17.
REQ-033 audio_demo 0->7 for 2 cycles ->0 -> press[7] set 2 edges after, stays set 8 cycles total, press_fall[7] one pulse.
REQ-034 audio_demo 3->4->5 one cycle apart -> press[3] cleared when 5 selected, press[4] held to DEMO_HOLD_CYCLES, press[5] current; audio_demo=20 -> no demo bit.
REQ-035 reset_n low mid-hold with press=17'h0082 -> all outputs 0 immediately, stay 0 first cycle after release.
